// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1 -- registered N-to-1 channel multiplexer with a valid/ready
// output. In direct mode it follows the caller's select; in scan mode it
// sweeps every channel once, waiting a programmable dwell before sampling
// each one, and pulses done after the last channel has been accepted.
module mux_scan_nx1 #(
   parameter int SELW   = 4,
   parameter int W      = 1,
   parameter int DWELLW = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [(2**SELW)*W-1:0] in_data,
   input  logic                  mode,
   input  logic [SELW-1:0]       sel,
   input  logic [DWELLW-1:0]     dwell,
   input  logic                  start,
   input  logic                  abort,
   output logic [W-1:0]          out_data,
   output logic [SELW-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int NCH = 2**SELW;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DWELL = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [SELW-1:0] LAST_CH = {SELW{1'b1}};

   logic [1:0]        state;
   logic [SELW-1:0]   ch;
   logic [DWELLW-1:0] cnt;

   logic [W-1:0]      chan [NCH];
   logic              slot_free;
   logic              handshake;
   logic              abort_act;
   logic              cap_en;
   logic [SELW-1:0]   cap_idx;

   // Split the flat input bus into one word per channel so the capture mux
   // can index by channel number directly.
   for (genvar k = 0; k < NCH; k++) begin : g_chan
      assign chan[k] = in_data[k*W +: W];
   end

   assign slot_free = !out_valid || out_ready;
   assign handshake = out_valid && out_ready;
   // abort only means something while a sweep is in progress.
   assign abort_act = abort && (state != ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // Decide whether this edge captures a new sample, and from which channel.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch; a path that leaves one unassigned infers a latch.
      cap_en  = 1'b0;
      cap_idx = ch;
      case (state)
         ST_IDLE: begin
            if (!mode && slot_free) begin
               cap_en  = 1'b1;
               cap_idx = sel;
            end
         end
         ST_DWELL: begin
            if (cnt == '0 && slot_free) begin
               cap_en = 1'b1;
            end
         end
         default: ;
      endcase
      if (abort_act) begin
         cap_en = 1'b0;
      end
   end

   // Output register: capture, hold under backpressure, or drop valid once the
   // consumer has taken the sample and nothing new replaces it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else if (abort_act) begin
         out_valid <= 1'b0;
      end else if (cap_en) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         out_data  <= chan[cap_idx];
         out_ch    <= cap_idx;
         out_valid <= 1'b1;
      end else if (handshake) begin
         out_valid <= 1'b0;
      end
   end

   // Sweep controller: IDLE -> (DWELL -> HOLD) per channel -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         ch    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_act) begin
            state <= ST_IDLE;
            ch    <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (mode && start) begin
                     ch    <= '0;
                     cnt   <= dwell;
                     state <= ST_DWELL;
                  end
               end
               ST_DWELL: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (slot_free) begin
                     state <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (handshake) begin
                     if (ch == LAST_CH) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end else begin
                        ch    <= ch + 1'b1;
                        cnt   <= dwell;
                        state <= ST_DWELL;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed testbench for mux_scan_nx1 with 16 channels of 8-bit data, where
// channel k carries 8'hA0+k. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_mux_scan_nx1;

   localparam int SELW   = 4;
   localparam int W      = 8;
   localparam int DWELLW = 8;
   localparam int NCH    = 2**SELW;

   logic                clk;
   logic                rst_n;
   logic [NCH*W-1:0]    in_data;
   logic                mode;
   logic [SELW-1:0]     sel;
   logic [DWELLW-1:0]   dwell;
   logic                start;
   logic                abort;
   logic [W-1:0]        out_data;
   logic [SELW-1:0]     out_ch;
   logic                out_valid;
   logic                out_ready;
   logic                busy;
   logic                done;

   int n_cmp = 0;
   int n_err = 0;

   mux_scan_nx1 #(.SELW(SELW), .W(W), .DWELLW(DWELLW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .mode      (mode),
      .sel       (sel),
      .dwell     (dwell),
      .start     (start),
      .abort     (abort),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected output schedule of the dwell=3 sweep with ch7 stalled at E40/E41.
   function automatic void stall_exp(input int e, output logic v, output int c);
      int cap;
      v = 1'b0;
      c = 0;
      for (int k = 0; k < NCH; k++) begin
         cap = (k <= 7) ? 5*k + 4 : 5*k + 6;
         if (e == cap) begin
            v = 1'b1;
            c = k;
         end
      end
      if (e == 40 || e == 41) begin
         v = 1'b1;
         c = 7;
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b1; sel = '0; dwell = '0;
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      #12;
      n_cmp++;
      if ({out_valid, busy, done, out_data, out_ch} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got v=%b b=%b d=%b data=%h ch=%0d want all 0",
                  out_valid, busy, done, out_data, out_ch);
      end
      rst_n = 1'b1;
      step();
      step();
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_direct();
      logic [W-1:0] exp_d;
      mode = 1'b0; out_ready = 1'b1; sel = 4'd5;
      step();
      n_cmp++;
      if (out_data !== 8'hA5 || out_ch !== 4'd5 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL direct_sel5 got data=%h ch=%0d v=%b want a5 5 1",
                  out_data, out_ch, out_valid);
      end
      for (int i = 0; i < NCH; i++) begin
         sel = SELW'(i);
         step();
         exp_d = 8'(8'hA0 + i);
         n_cmp++;
         if (out_data !== exp_d || out_ch !== SELW'(i)) begin
            n_err++;
            $display("FAIL direct_step sel=%0d got data=%h ch=%0d want %h %0d",
                     i, out_data, out_ch, exp_d, i);
         end
      end
   endtask

   task automatic test_backpressure();
      sel = 4'd5; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      sel = 4'd9;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (out_data !== 8'hA5 || out_ch !== 4'd5 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold cyc=%0d got data=%h ch=%0d v=%b want a5 5 1",
                     i, out_data, out_ch, out_valid);
         end
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (out_data !== 8'hA9 || out_ch !== 4'd9) begin
         n_err++;
         $display("FAIL bp_release got data=%h ch=%0d want a9 9", out_data, out_ch);
      end
   endtask

   task automatic test_scan_dwell0();
      logic [W-1:0] exp_d;
      int exp_c;
      mode = 1'b1; dwell = 8'd0; out_ready = 1'b1;
      step();
      step();
      start = 1'b1;
      step();                       // E0
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL scan0_start got busy=%b v=%b want 1 0", busy, out_valid);
      end
      for (int e = 1; e <= 33; e++) begin
         step();
         n_cmp++;
         if (out_valid !== ((e % 2 == 1) && e <= 31)) begin
            n_err++;
            $display("FAIL scan0_valid E%0d got %b want %b", e, out_valid,
                     (e % 2 == 1) && e <= 31);
         end
         if (e % 2 == 1 && e <= 31) begin
            exp_c = (e - 1) / 2;
            exp_d = 8'(8'hA0 + exp_c);
            n_cmp++;
            if (out_ch !== SELW'(exp_c) || out_data !== exp_d) begin
               n_err++;
               $display("FAIL scan0_sample E%0d got ch=%0d data=%h want %0d %h",
                        e, out_ch, out_data, exp_c, exp_d);
            end
         end
         n_cmp++;
         if (done !== (e == 32) || busy !== (e < 32)) begin
            n_err++;
            $display("FAIL scan0_ctl E%0d got done=%b busy=%b want %b %b",
                     e, done, busy, e == 32, e < 32);
         end
      end
   endtask

   task automatic test_scan_stall();
      logic   ev;
      int     ec;
      int     n_done = 0;
      logic [W-1:0] exp_d;
      dwell = 8'd3; out_ready = 1'b1;
      start = 1'b1;
      step();                       // E0
      start = 1'b0;
      for (int e = 1; e <= 90; e++) begin
         out_ready = !(e == 40 || e == 41);
         start     = (e == 20);     // ignored: sweep in progress
         step();
         stall_exp(e, ev, ec);
         n_cmp++;
         if (out_valid !== ev) begin
            n_err++;
            $display("FAIL stall_valid E%0d got %b want %b", e, out_valid, ev);
         end
         if (ev) begin
            exp_d = 8'(8'hA0 + ec);
            n_cmp++;
            if (out_ch !== SELW'(ec) || out_data !== exp_d) begin
               n_err++;
               $display("FAIL stall_sample E%0d got ch=%0d data=%h want %0d %h",
                        e, out_ch, out_data, ec, exp_d);
            end
         end
         if (done === 1'b1) n_done++;
         n_cmp++;
         if (done !== (e == 82) || busy !== (e < 82)) begin
            n_err++;
            $display("FAIL stall_ctl E%0d got done=%b busy=%b want %b %b",
                     e, done, busy, e == 82, e < 82);
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (n_done != 1) begin
         n_err++;
         $display("FAIL stall_done_count got %0d want 1", n_done);
      end
   endtask

   task automatic test_abort();
      dwell = 8'd3; out_ready = 1'b1;
      start = 1'b1;
      step();                       // E0
      start = 1'b0;
      for (int e = 1; e <= 21; e++) step();
      n_cmp++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL abort_pre got busy=%b v=%b want 1 0", busy, out_valid);
      end
      abort = 1'b1;
      step();                       // E22, ch4 in DWELL
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle cyc=%0d got busy=%b v=%b done=%b want 0 0 0",
                     i, busy, out_valid, done);
         end
         step();
      end
      start = 1'b1;
      step();                       // new E0
      start = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         n_cmp++;
         if (out_valid !== (e == 4)) begin
            n_err++;
            $display("FAIL restart_valid E%0d got %b want %b", e, out_valid, e == 4);
         end
      end
      n_cmp++;
      if (out_ch !== 4'd0 || out_data !== 8'hA0) begin
         n_err++;
         $display("FAIL restart_sample got ch=%0d data=%h want 0 a0", out_ch, out_data);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      dwell = 8'd0; out_ready = 1'b1; mode = 1'b1;
      start = 1'b1;
      step();                       // E0
      start = 1'b0;
      step();
      step();
      step();                       // E3: ch1 valid
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 4'd1 || out_data !== 8'hA1) begin
         n_err++;
         $display("FAIL areset_pre got v=%b ch=%0d data=%h want 1 1 a1",
                  out_valid, out_ch, out_data);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, busy, done, out_data, out_ch} !== '0) begin
         n_err++;
         $display("FAIL areset_now got v=%b b=%b d=%b data=%h ch=%0d want all 0",
                  out_valid, busy, done, out_data, out_ch);
      end
      #2 rst_n = 1'b1;
      step();
      step();
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL areset_idle got busy=%b v=%b want 0 0", busy, out_valid);
      end
   endtask

   initial begin
      for (int k = 0; k < NCH; k++) begin
         in_data[k*W +: W] = 8'(8'hA0 + k);
      end
      test_reset();
      test_direct();
      test_backpressure();
      test_scan_dwell0();
      test_scan_stall();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised registered N-to-1 channel multiplexer with a valid/ready output and two modes: direct (caller-driven select) and scan (autonomous sweep of every channel with a programmable dwell per channel). It generalises the fixed 16x1 selector to arbitrary select and data widths. It sits between a bank of sampled input channels and a single downstream consumer, such as a serialiser, logger or comparator.

## Interface
- SELW, 4, select width; channel count NCH = 2**SELW
- W, 1, data width per channel
- DWELLW, 8, width of dwell counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NCH*W  channel k occupies bits [k*W +: W]
- mode  in  1  0 = direct, 1 = scan; sampled only in IDLE
- sel  in  SELW  channel index, direct mode
- dwell  in  DWELLW  cycles to wait before sampling each channel in scan; sampled at start and at each channel reload
- start  in  1  begin a scan sweep (mode=1, IDLE only)
- abort  in  1  synchronous sweep abort
- out_data  out  W  registered sample
- out_ch  out  SELW  channel index of out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high in DWELL or HOLD
- done  out  1  one-cycle pulse after last channel accepted

## Operation
- Reset: state IDLE, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, ch=0, cnt=0.
- slot_free = !out_valid || out_ready.
- Capture means: out_data<=in_data[ch*W +: W], out_ch<=ch, out_valid<=1.
- If out_valid && !out_ready, then out_data and out_ch hold stable regardless of inputs.
- Handshake with no new capture: out_valid<=0.
- IDLE, mode=0: every cycle that slot_free holds, capture channel sel.
- IDLE, mode=1:
  - No capture; a pending sample drains normally.
  - If start, then ch<=0, cnt<=dwell, go to DWELL.
- DWELL:
  - If cnt!=0, then cnt<=cnt-1.
  - If cnt==0 && slot_free, then capture ch and go to HOLD.
  - If cnt==0 && !slot_free, then wait in DWELL.
- HOLD: on handshake:
  - If ch==NCH-1, then done<=1 for one cycle, go to IDLE.
  - Else ch<=ch+1, cnt<=dwell, go to DWELL.
- abort, any state other than IDLE: go to IDLE, out_valid<=0, ch<=0, no done pulse. abort has priority over every other transition. abort in IDLE has no effect.
- start while busy is ignored. Changes to mode while busy are ignored.
- Channel index wraps never: the sweep always ends after NCH-1.
- dwell=0 is legal: sample on the first DWELL cycle.

## Timing
- Direct mode latency: 1 cycle. sel/in_data at edge E appear on out_data after E, when slot_free.
- Scan timing, with start sampled at edge E0:
  - First out_valid rises after edge E(dwell+1).
  - With out_ready=1 throughout, channel period = dwell+2 cycles.
  - Last sample is valid after E(NCH*(dwell+2)-1).
  - done is high for the cycle after edge E(NCH*(dwell+2)).
- Stalls: each out_ready=0 cycle in HOLD extends the sweep by one cycle. Dwell does not count during HOLD.
- rst_n is asynchronous on assertion. Mid-sweep reset returns all outputs to reset values immediately.

## Test plan
- Reset: assert rst_n=0 mid-sweep, off-edge -> out_valid, busy, done, out_data, out_ch are all 0 immediately; IDLE after release.
- Direct, out_ready=1: SELW=4, W=8, in_data channel k = 8'hA0+k, sel=5 -> next cycle out_data=8'hA5, out_ch=5. Step sel 0..15 -> data follows with 1-cycle lag.
- Direct backpressure: out_ready=0 for 3 cycles while sel changes 5->9 -> out_data stays 8'hA5. The first cycle after out_ready=1 shows 8'hA9.
- Scan, dwell=0, out_ready=1, start at E0 -> out_valid at E1, E3, …, E31 with out_ch 0..15 and matching data. done pulse after E32. busy low after E32.
- Scan, dwell=3, out_ready low for 2 cycles on channel 7 -> sweep ends 2 cycles later than 16*5. No channel is skipped or duplicated. start pulsed mid-sweep is ignored.
- Abort during DWELL of channel 4 -> IDLE next cycle, out_valid=0, no done. A new start sweeps again from channel 0.
